// File: rtl/photon_pipe_elastic.sv
// Elastic register pipeline of DEPTH stages with bubble collapsing, global enable and flush.
// Entries advance into any free stage, so back-pressure compacts occupancy toward the output.
module photon_pipe_elastic #(
    parameter int               WIDTH     = 32,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    localparam int              CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             flush,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    input  logic             o_ready,
    output logic [CNT_W-1:0] o_count
);

    logic [DEPTH-1:0] vld_q;
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] move;
    logic [DEPTH-1:0] leave;
    logic             advance;
    logic             out_xfer;
    logic             stage0_free;

    assign advance  = enable & ~flush;
    assign o_valid  = vld_q[DEPTH-1] & enable;
    assign out_xfer = o_valid & o_ready;
    assign o_data   = data_q[DEPTH-1];
    // reset gates i_ready so an empty pipe does not advertise space while held in reset
    assign i_ready  = reset & advance & stage0_free;

    // Free-ness ripples from the output back to stage 0: a stage is free if empty
    // or if its occupant moves on this cycle.
    always_comb begin
        logic free_k;
        move        = '0;
        leave       = '0;
        leave[DEPTH-1] = out_xfer;
        free_k      = ~vld_q[DEPTH-1] | out_xfer;
        for (int k = DEPTH - 1; k >= 1; k--) begin
            move[k]      = advance & vld_q[k-1] & free_k;
            leave[k-1]   = move[k];
            free_k       = ~vld_q[k-1] | move[k];
        end
        stage0_free = free_k;
        move[0]     = i_valid & i_ready;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
        end else if (flush) begin
            vld_q <= '0;
        end else if (enable) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (move[k])
                    vld_q[k] <= 1'b1;
                else if (leave[k])
                    vld_q[k] <= 1'b0;
            end
        end
    end

    // Data registers load only when an entry enters, so o_data holds while o_valid is low.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++)
                data_q[k] <= RESET_VAL;
        end else begin
            if (move[0])
                data_q[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                if (move[k])
                    data_q[k] <= data_q[k-1];
            end
        end
    end

    always_comb begin
        o_count = '0;
        for (int k = 0; k < DEPTH; k++)
            o_count = o_count + CNT_W'(vld_q[k]);
    end

endmodule

// File: tb/tb_photon_pipe_elastic.sv
// Scoreboard bench for photon_pipe_elastic (WIDTH=32, DEPTH=4): accepted inputs are queued,
// a negedge monitor pops and compares on every output transfer; directed checks cover timing.
module tb_photon_pipe_elastic;

    logic        clock   = 1'b0;
    logic        reset   = 1'b0;
    logic        enable  = 1'b1;
    logic        flush   = 1'b0;
    logic        i_valid = 1'b0;
    logic [31:0] i_data  = '0;
    logic        i_ready;
    logic        o_valid;
    logic [31:0] o_data;
    logic        o_ready = 1'b0;
    logic [2:0]  o_count;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];

    photon_pipe_elastic #(.WIDTH(32), .DEPTH(4), .RESET_VAL(32'h0)) dut (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .flush  (flush),
        .i_valid(i_valid),
        .i_data (i_data),
        .i_ready(i_ready),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_ready(o_ready),
        .o_count(o_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: transfers happen at the next posedge, so sample at the negedge before it.
    always @(negedge clock) begin
        if (reset) begin
            if (o_valid && o_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL out_unexpected: got 0x%0h expected none", o_data);
                end else begin
                    check("out_data", o_data, exp_q.pop_front());
                end
            end
            if (i_valid && i_ready)
                exp_q.push_back(i_data);
            if (flush)
                exp_q.delete();
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        o_ready = 1'b1;
        i_valid = 1'b0;
        @(negedge clock);
        while (o_count != 0 && n < 40) begin
            @(negedge clock);
            n++;
        end
        check(name, o_count, 0);
        next_cycle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        logic [2:0]  scnt;
        logic [31:0] sdata;

        // Reset state
        #2;
        check("rst_o_valid", o_valid, 0);
        check("rst_i_ready", i_ready, 0);
        check("rst_o_count", o_count, 0);
        check("rst_o_data",  o_data,  0);
        @(negedge clock);
        reset = 1'b1;
        next_cycle();

        // Stream 1..8, o_ready=1: o_valid rises 4 cycles after first accept
        for (int j = 0; j <= 12; j++) begin
            i_valid = (j < 8);
            i_data  = 32'(j + 1);
            o_ready = 1'b1;
            @(negedge clock);
            if (j == 0) check("first_edge_i_ready", i_ready, 1);
            check("stream_o_valid", o_valid, (j >= 4 && j <= 11));
            check("stream_o_count", o_count, (j <= 8) ? ((j < 4) ? j : 4) : (12 - j));
            next_cycle();
        end
        i_valid = 1'b0;

        // Back-pressure: 6 offered, 4 accepted
        o_ready = 1'b0;
        acc = 0;
        for (int j = 0; j < 6; j++) begin
            i_valid = 1'b1;
            i_data  = 32'h11 + 32'(acc);
            @(negedge clock);
            check("bp_i_ready", i_ready, (j < 4));
            if (i_ready) acc++;
            next_cycle();
        end
        @(negedge clock);
        check("bp_o_count", o_count, 4);
        next_cycle();
        o_ready = 1'b1;
        n = 0;
        while (acc < 6 && n < 20) begin
            i_valid = 1'b1;
            i_data  = 32'h11 + 32'(acc);
            @(negedge clock);
            if (i_ready) acc++;
            next_cycle();
            n++;
        end
        check("bp_all_accepted", acc, 6);
        drain("bp_drain");

        // Bubbles collapse: A,_,B,_,C under o_ready=0
        o_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
            i_valid = (j % 2 == 0);
            i_data  = 32'hA + 32'(j / 2);
            next_cycle();
        end
        i_valid = 1'b0;
        repeat (3) next_cycle();
        @(negedge clock);
        check("bubble_o_count", o_count, 3);
        next_cycle();
        o_ready = 1'b1;
        for (int r = 0; r < 4; r++) begin
            @(negedge clock);
            check("bubble_o_valid", o_valid, (r < 3));
            next_cycle();
        end
        @(negedge clock);
        check("bubble_empty", o_count, 0);
        next_cycle();

        // Full pipe, one in / one out per cycle
        o_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            i_valid = 1'b1;
            i_data  = 32'h20 + 32'(j);
            next_cycle();
        end
        i_valid = 1'b0;
        @(negedge clock);
        check("full_o_count", o_count, 4);
        next_cycle();
        for (int c = 0; c < 10; c++) begin
            i_valid = 1'b1;
            i_data  = 32'h24 + 32'(c);
            o_ready = 1'b1;
            @(negedge clock);
            check("full_i_ready", i_ready, 1);
            check("full_o_valid", o_valid, 1);
            check("full_o_count_steady", o_count, 4);
            next_cycle();
        end
        drain("full_drain");

        // Flush with 3 entries: head delivered, rest discarded
        o_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            i_valid = 1'b1;
            i_data  = 32'h30 + 32'(j);
            next_cycle();
        end
        i_valid = 1'b0;
        repeat (3) next_cycle();
        @(negedge clock);
        check("flush_pre_count", o_count, 3);
        next_cycle();
        flush   = 1'b1;
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'h99;
        @(negedge clock);
        check("flush_i_ready", i_ready, 0);
        check("flush_head_valid", o_valid, 1);
        check("flush_head_data", o_data, 32'h30);
        next_cycle();
        flush   = 1'b0;
        i_valid = 1'b0;
        @(negedge clock);
        check("flush_post_count", o_count, 0);
        check("flush_post_valid", o_valid, 0);
        next_cycle();
        i_valid = 1'b1;
        i_data  = 32'h33;
        next_cycle();
        drain("flush_drain");

        // Enable low for 2 cycles mid-stream
        o_ready = 1'b1;
        n = 0;
        scnt = '0;
        sdata = '0;
        for (int c = 0; c < 16; c++) begin
            enable  = !(c == 3 || c == 4);
            i_valid = (n < 8);
            i_data  = 32'h40 + 32'(n);
            @(negedge clock);
            if (c == 3 || c == 4) begin
                check("en_o_valid", o_valid, 0);
                check("en_i_ready", i_ready, 0);
            end
            if (c == 3) begin
                scnt  = o_count;
                sdata = o_data;
            end
            if (c == 4) begin
                check("en_count_hold", o_count, scnt);
                check("en_data_hold", o_data, sdata);
            end
            if (c == 5) check("en_count_after", o_count, scnt);
            if (i_valid && i_ready) n++;
            next_cycle();
        end
        enable = 1'b1;
        check("en_all_accepted", n, 8);
        drain("en_drain");

        // Asynchronous reset mid-operation with 2 entries held
        o_ready = 1'b0;
        for (int j = 0; j < 2; j++) begin
            i_valid = 1'b1;
            i_data  = 32'h50 + 32'(j);
            next_cycle();
        end
        i_valid = 1'b0;
        repeat (4) next_cycle();
        @(negedge clock);
        check("arst_pre_count", o_count, 2);
        check("arst_pre_valid", o_valid, 1);
        check("arst_pre_data", o_data, 32'h50);
        #2;
        reset = 1'b0;
        #1;
        check("arst_o_valid", o_valid, 0);
        check("arst_o_count", o_count, 0);
        check("arst_o_data", o_data, 32'h0);
        check("arst_i_ready", i_ready, 0);
        exp_q.delete();
        @(posedge clock);
        #3;
        reset   = 1'b1;
        i_valid = 1'b1;
        i_data  = 32'h60;
        o_ready = 1'b1;
        @(negedge clock);
        check("post_rst_i_ready", i_ready, 1);
        next_cycle();
        drain("post_rst_drain");

        check("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
